imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Boot-time program loader that sits directly upstream of the two-phase RISC_MIPS core.
- Accepts a framed byte stream over a valid/ready interface and assembles big-endian 32-bit instruction words. Each word is written into the core's unified MEM array through a single write port.
- Holds the core in reset until a complete, checksum-verified image is in memory, then releases it.
- Replaces hierarchical MEM pokes with a synthesizable load path.

Parameters:
- ADDR_W, 10, memory word-address width.
- MEM_DEPTH, 1024, number of 32-bit words in MEM.
- START_ADDR, 0, word address of the first instruction written.

Ports:
- CLK  in  1  single system clock, rising-edge.
- RST_N  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse that begins a load. Accepted only in IDLE, DONE or ERR.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader can accept a byte. A byte transfers on a cycle where in_valid && in_ready.
- mem_we  out  1  one-cycle write strobe to MEM.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  32  word data.
- cpu_hold  out  1  drives the core's RST. 1 = core held in reset.
- load_done  out  1  level; image loaded and checksum good.
- load_err  out  1  level; length overflow or checksum mismatch.
- words_loaded  out  ADDR_W+1  count of words written in the current load.

Behaviour:
- Reset (RST_N=0 at a clock edge):
  - state=IDLE.
  - in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - cpu_hold=1, load_done=0, load_err=0, words_loaded=0.
- Frame format, in order:
  - LEN_HI, LEN_LO: 16-bit word count N.
  - N x 4 payload bytes, MSB first.
  - CSUM byte.
  - CSUM must equal (LEN_HI + LEN_LO + all payload bytes) mod 256.
- FSM states: IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERR.
  - IDLE/DONE/ERR + start: go to LEN_HI. Set cpu_hold=1; clear load_done, load_err, words_loaded and the running sum; set mem_addr=START_ADDR.
  - LEN_HI: on a byte transfer, go to LEN_LO.
  - LEN_LO: on a byte transfer, check N.
    - N > MEM_DEPTH-START_ADDR: go to ERR.
    - N = 0: go to CSUM.
    - Otherwise: go to DATA.
  - DATA: a 2-bit byte counter shifts bytes into a 32-bit assembly register.
    - On the 4th byte: mem_wdata and mem_addr are registered, and mem_we=1 on the next cycle (1-cycle latency from the 4th byte transfer).
    - mem_addr increments after each write. words_loaded increments in the same cycle mem_we is high.
    - After word N, go to CSUM.
  - CSUM: on a byte transfer, compare with the running sum.
    - Match: go to DONE; load_done=1 and cpu_hold=0 one cycle after the CSUM byte transfer.
    - Mismatch: go to ERR; load_err=1 and cpu_hold stays 1.
  - DONE/ERR: hold until start or reset.
- in_ready:
  - 1 in LEN_HI, LEN_LO, DATA and CSUM.
  - 0 in IDLE, DONE and ERR.
  - 0 in the cycle mem_we is asserted, so no byte is accepted during a write. Bytes therefore arrive at most 4 per 5 cycles.
- Running sum: 8-bit, wraps modulo 256, includes the length bytes.
- mem_addr: never wraps; the length check guarantees the final address is START_ADDR+N-1 ≤ MEM_DEPTH-1.
- start during an active load (LEN_HI..CSUM): ignored.
- in_valid while in_ready=0: no transfer, byte not consumed.
- Reset mid-load: aborts immediately to the reset state. Partially written MEM contents are not restored, and cpu_hold=1.

Optional Feature:
- Macro IMEM_LOADER_CLEAR_EN.
- Defined:
  - On start, the FSM first enters a CLEAR state and writes 32'd0 to addresses 0..MEM_DEPTH-1, one word per cycle with mem_we=1, in_ready=0.
  - It then goes to LEN_HI with mem_addr=START_ADDR.
  - A cleared MEM_DEPTH costs MEM_DEPTH cycles before the first byte is accepted.
- Not defined: no CLEAR state; MEM words outside the loaded image keep their prior contents.

Test Plan:
- Good 2-word load: start, then bytes 00 02 28 01 00 05 FC 00 00 00 2C. Required response:
  - MEM[0]=0x28010005 (ADDI R1,R0,5) and MEM[1]=0xFC000000 (HLT).
  - Two mem_we pulses; words_loaded=2.
  - load_done=1 and cpu_hold=0 one cycle after the 0x2C transfer.
  - The core then halts with R1=5.
- Bad checksum: same frame with final byte 2D. Required response:
  - load_err=1, load_done=0, cpu_hold stays 1.
  - MEM[0..1] were still written.
- Length overflow: LEN=0x0401 with START_ADDR=0. Required response: ERR right after LEN_LO, no mem_we, in_ready=0.
- Backpressure and gaps: in_valid toggled randomly. Required response:
  - Identical MEM contents to the first scenario.
  - in_ready=0 in each mem_we cycle.
  - No byte lost or duplicated.
- Reset mid-DATA: RST_N=0 for 1 cycle after 5 payload bytes. Required response:
  - All outputs at reset values.
  - A subsequent full good load succeeds with words_loaded=2.
- N=0 frame: 00 00 00. Required response: load_done=1, no writes. With IMEM_LOADER_CLEAR_EN: 1024 zero writes precede acceptance of the first byte.

Source files
------------

// File: rtl/imem_loader.sv
// Boot loader: framed byte stream -> big-endian 32-bit words into core MEM.
// Optional `IMEM_LOADER_CLEAR_EN zero-fills all of MEM before each load.
module imem_loader #(
    parameter int ADDR_W     = 10,
    parameter int MEM_DEPTH  = 1024,
    parameter int START_ADDR = 0
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   words_loaded
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERR,
        ST_CLEAR
    } state_e;

    localparam logic [31:0]       MAX_WORDS = 32'(MEM_DEPTH - START_ADDR);
    localparam logic [ADDR_W-1:0] FIRST     = ADDR_W'(START_ADDR);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   WORD_ONE  = (ADDR_W+1)'(1);

    state_e              state_q, state_d;
    logic                in_ready_q, in_ready_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic                cpu_hold_q, cpu_hold_d;
    logic                load_done_q, load_done_d;
    logic                load_err_q, load_err_d;
    logic [ADDR_W:0]     words_q, words_d;
    logic [7:0]          sum_q, sum_d;
    logic [7:0]          len_hi_q, len_hi_d;
    logic [15:0]         rem_q, rem_d;
    logic [1:0]          bcnt_q, bcnt_d;
    logic [23:0]         asm_q, asm_d;

    logic                xfer;
    logic [15:0]         len_w;

    assign xfer  = in_valid && in_ready_q;
    assign len_w = {len_hi_q, in_data};

    always_comb begin
        state_d     = state_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_hold_d  = cpu_hold_q;
        load_done_d = load_done_q;
        load_err_d  = load_err_q;
        words_d     = words_q;
        sum_d       = sum_q;
        len_hi_d    = len_hi_q;
        rem_d       = rem_q;
        bcnt_d      = bcnt_q;
        asm_d       = asm_q;

        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    cpu_hold_d  = 1'b1;
                    load_done_d = 1'b0;
                    load_err_d  = 1'b0;
                    words_d     = '0;
                    sum_d       = '0;
                    bcnt_d      = '0;
                    rem_d       = '0;
`ifdef IMEM_LOADER_CLEAR_EN
                    state_d     = ST_CLEAR;
                    mem_addr_d  = '0;
                    mem_wdata_d = '0;
                    mem_we_d    = 1'b1;
`else
                    state_d     = ST_LEN_HI;
                    mem_addr_d  = FIRST;
`endif
                end
            end
            ST_CLEAR: begin
`ifdef IMEM_LOADER_CLEAR_EN
                // Each cycle here is a write of the current address.
                if (mem_addr_q == ADDR_W'(MEM_DEPTH - 1)) begin
                    state_d    = ST_LEN_HI;
                    mem_addr_d = FIRST;
                end else begin
                    mem_we_d   = 1'b1;
                    mem_addr_d = mem_addr_q + ADDR_ONE;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_LEN_HI: begin
                if (xfer) begin
                    len_hi_d = in_data;
                    sum_d    = sum_q + in_data;
                    state_d  = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (xfer) begin
                    sum_d = sum_q + in_data;
                    rem_d = len_w;
                    if ({16'd0, len_w} > MAX_WORDS) begin
                        state_d    = ST_ERR;
                        load_err_d = 1'b1;
                    end else if (len_w == 16'd0) begin
                        state_d = ST_CSUM;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (xfer) begin
                    sum_d  = sum_q + in_data;
                    bcnt_d = bcnt_q + 2'd1;
                    asm_d  = {asm_q[15:0], in_data};
                    if (bcnt_q == 2'd3) begin
                        mem_wdata_d = {asm_q, in_data};
                        mem_we_d    = 1'b1;
                        words_d     = words_q + WORD_ONE;
                        rem_d       = rem_q - 16'd1;
                        if (rem_q == 16'd1) begin
                            state_d = ST_CSUM;
                        end
                    end
                end
            end
            ST_CSUM: begin
                if (xfer) begin
                    if (in_data == sum_q) begin
                        state_d     = ST_DONE;
                        load_done_d = 1'b1;
                        cpu_hold_d  = 1'b0;
                    end else begin
                        state_d    = ST_ERR;
                        load_err_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Advance only while words remain so the address never wraps.
        if (mem_we_q && state_q != ST_CLEAR && rem_q != 16'd0) begin
            mem_addr_d = mem_addr_q + ADDR_ONE;
        end
    end

    always_comb begin
        in_ready_d = 1'b0;
        unique case (state_d)
            ST_LEN_HI, ST_LEN_LO, ST_DATA, ST_CSUM: in_ready_d = !mem_we_d;
            default:                               in_ready_d = 1'b0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_hold_q  <= 1'b1;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
            words_q     <= '0;
            sum_q       <= '0;
            len_hi_q    <= '0;
            rem_q       <= '0;
            bcnt_q      <= '0;
            asm_q       <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_hold_q  <= cpu_hold_d;
            load_done_q <= load_done_d;
            load_err_q  <= load_err_d;
            words_q     <= words_d;
            sum_q       <= sum_d;
            len_hi_q    <= len_hi_d;
            rem_q       <= rem_d;
            bcnt_q      <= bcnt_d;
            asm_q       <= asm_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign cpu_hold     = cpu_hold_q;
    assign load_done    = load_done_q;
    assign load_err     = load_err_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: good/bad loads, overflow, gaps, reset.
// A MEM model records every write strobe seen on the write port.
module tb_imem_loader;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  in_data = 8'hA5;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        load_done;
    logic        load_err;
    logic [10:0] words_loaded;

`ifdef IMEM_LOADER_CLEAR_EN
    localparam int CLR = 1024;
`else
    localparam int CLR = 0;
`endif

    imem_loader dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .start        (start),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_hold     (cpu_hold),
        .load_done    (load_done),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int we_cnt = 0;
    int rdy_viol = 0;
    int base;
    logic [31:0] mem [0:1023];
    logic [7:0]  good [$] = '{8'h00, 8'h02, 8'h28, 8'h01, 8'h00, 8'h05,
                             8'hFC, 8'h00, 8'h00, 8'h00, 8'h2C};

    always @(negedge CLK) begin
        if (mem_we) begin
            mem[mem_addr] = mem_wdata;
            we_cnt++;
            if (in_ready) rdy_viol++;
        end
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge CLK);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int t;
        if (gaps) begin
            repeat ($urandom_range(0, 3)) @(negedge CLK);
        end
        in_data  = b;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 3000) begin
            @(negedge CLK);
            t++;
        end
        if (t >= 3000) check("rdy_timeout", in_ready, 1);
        @(negedge CLK);
        in_valid = 1'b0;
        in_data  = 8'hA5;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rdy"},   in_ready, 0);
        check({tag, "_we"},    mem_we, 0);
        check({tag, "_addr"},  mem_addr, 0);
        check({tag, "_wdata"}, mem_wdata, 0);
        check({tag, "_hold"},  cpu_hold, 1);
        check({tag, "_done"},  load_done, 0);
        check({tag, "_err"},   load_err, 0);
        check({tag, "_words"}, words_loaded, 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'hDEADBEEF;
        repeat (2) @(negedge CLK);
        check_reset_vals("rst");
        RST_N = 1'b1;

        // good 2-word load
        base = we_cnt;
        pulse_start();
        check("g_hold0", cpu_hold, 1);
        for (int i = 0; i < 10; i++) send_byte(good[i], 1'b0);
        check("g_hold_pre", cpu_hold, 1);
        check("g_done_pre", load_done, 0);
        send_byte(8'h2C, 1'b0);
        check("g_done", load_done, 1);
        check("g_hold", cpu_hold, 0);
        check("g_err", load_err, 0);
        check("g_words", words_loaded, 2);
        check("g_addr", mem_addr, 1);
        check("g_mem0", mem[0], 32'h28010005);
        check("g_mem1", mem[1], 32'hFC000000);
        check("g_wecnt", we_cnt - base, 2 + CLR);

        // bad checksum
        mem[0] = 32'h0;
        mem[1] = 32'h0;
        pulse_start();
        for (int i = 0; i < 10; i++) send_byte(good[i], 1'b0);
        send_byte(8'h2D, 1'b0);
        check("b_err", load_err, 1);
        check("b_done", load_done, 0);
        check("b_hold", cpu_hold, 1);
        check("b_mem0", mem[0], 32'h28010005);
        check("b_mem1", mem[1], 32'hFC000000);

        // length overflow
        base = we_cnt;
        pulse_start();
        send_byte(8'h04, 1'b0);
        send_byte(8'h01, 1'b0);
        check("o_err", load_err, 1);
        check("o_rdy", in_ready, 0);
        check("o_done", load_done, 0);
        repeat (3) @(negedge CLK);
        check("o_wecnt", we_cnt - base, CLR);

        // backpressure and gaps
        mem[0] = 32'h0;
        mem[1] = 32'h0;
        pulse_start();
        foreach (good[i]) send_byte(good[i], 1'b1);
        check("p_done", load_done, 1);
        check("p_words", words_loaded, 2);
        check("p_mem0", mem[0], 32'h28010005);
        check("p_mem1", mem[1], 32'hFC000000);

        // reset mid-DATA, with an ignored start along the way
        pulse_start();
        for (int i = 0; i < 7; i++) send_byte(good[i], 1'b0);
        check("r_words1", words_loaded, 1);
        pulse_start();
        check("r_ign_words", words_loaded, 1);
        check("r_ign_rdy", in_ready, 1);
        @(negedge CLK);
        RST_N = 1'b0;
        @(negedge CLK);
        check_reset_vals("mid");
        RST_N = 1'b1;
        pulse_start();
        foreach (good[i]) send_byte(good[i], 1'b0);
        check("r_done", load_done, 1);
        check("r_words", words_loaded, 2);

        // N=0 frame
        base = we_cnt;
        pulse_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        check("z_done", load_done, 1);
        check("z_words", words_loaded, 0);
        check("z_wecnt", we_cnt - base, CLR);

        // N = MEM_DEPTH is accepted
        pulse_start();
        send_byte(8'h04, 1'b0);
        send_byte(8'h00, 1'b0);
        check("m_err", load_err, 0);
        check("m_rdy", in_ready, 1);

        check("rdy_viol", rdy_viol, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
